alu_exec_seq: RTL and testbench

Execute-stage arithmetic unit sitting directly downstream of the rs2 operand-routing stage of the 16-bit CPU. Accepts a 2-bit opcode plus both source-register values, performs unsigned add, subtract, multiply or divide, and returns a registered result over a valid/ready handshake. Add and subtract complete in one cycle; multiply (shift-add) and divide (restoring) iterate over 16 cycles, so the unit back-pressures issue while busy.

---
 rtl/alu_exec_seq_if.sv | 30 +++
 rtl/alu_exec_seq.sv | 151 +++++++++++++++
 tb/tb_alu_exec_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_seq_if.sv
// Issue/result bus of the execute-stage ALU. The issuing stage drives the
// operands; the ALU drives the result and status flags.
interface alu_exec_seq_if #(
  parameter int WIDTH = 16
);
  // Both channels use valid/ready. A transfer happens on a rising edge where
  // valid && ready. The sender holds valid and its payload steady until that
  // edge. Ready never depends combinationally on valid.
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             div_by_zero;

  modport master (
    output in_valid, opcode, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, div_by_zero
  );

  modport slave (
    input  in_valid, opcode, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, result, result_hi, carry, div_by_zero
  );
endinterface

// File: rtl/alu_exec_seq.sv
// Execute-stage unsigned ALU: single-cycle add/sub, 16-step shift-add multiply
// and restoring divide, with a registered result held until it is consumed.
module alu_exec_seq #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_exec_seq_if.slave       bus,
  output logic [1:0]          o_state
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_is_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;     // multiplicand, or divisor
  logic [WIDTH-1:0]   r_opb;     // multiplier, or dividend shifting into quotient
  logic [2*WIDTH-1:0] r_acc;     // product accumulator, or remainder in the low half
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry;
  logic               r_dbz;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic               w_last;

  assign w_sum  = {1'b0, bus.rs1_val} + {1'b0, bus.rs2_val};
  assign w_diff = {1'b0, bus.rs1_val} - {1'b0, bus.rs2_val};

  assign w_addend   = r_opb[0] ? ({{WIDTH{1'b0}}, r_opa} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;

  // The shifted remainder is below 2*divisor, so bit WIDTH of the trial
  // subtraction is set exactly when it went negative.
  assign w_rem_sh   = {r_acc[WIDTH-1:0], r_opb[WIDTH-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_opa};
  assign w_ge       = ~w_rem_sub[WIDTH];
  assign w_rem_next = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_opb[WIDTH-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            case (bus.opcode)
              2'b00: begin
                r_result    <= w_sum[WIDTH-1:0];
                r_carry     <= w_sum[WIDTH];
                r_result_hi <= '0;
                r_dbz       <= 1'b0;
                r_state     <= S_DONE;
              end
              2'b01: begin
                r_result    <= w_diff[WIDTH-1:0];
                r_carry     <= w_diff[WIDTH];
                r_result_hi <= '0;
                r_dbz       <= 1'b0;
                r_state     <= S_DONE;
              end
              2'b10: begin
                r_opa    <= bus.rs1_val;
                r_opb    <= bus.rs2_val;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_is_div <= 1'b0;
                r_state  <= S_ITER;
              end
              default: begin
                if (bus.rs2_val == '0) begin
                  r_result    <= '1;
                  r_result_hi <= bus.rs1_val;
                  r_carry     <= 1'b0;
                  r_dbz       <= 1'b1;
                  r_state     <= S_DONE;
                end else begin
                  r_opa    <= bus.rs2_val;
                  r_opb    <= bus.rs1_val;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_is_div <= 1'b1;
                  r_state  <= S_ITER;
                end
              end
            endcase
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_acc <= {{WIDTH{1'b0}}, w_rem_next};
            r_opb <= w_quo_next;
          end else begin
            r_acc <= w_acc_next;
            r_opb <= r_opb >> 1;
          end
          if (w_last) begin
            r_carry <= 1'b0;
            r_dbz   <= 1'b0;
            r_state <= S_DONE;
            if (r_is_div) begin
              r_result    <= w_quo_next;
              r_result_hi <= w_rem_next;
            end else begin
              r_result    <= w_acc_next[WIDTH-1:0];
              r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.result_hi   = r_result_hi;
  assign bus.carry       = r_carry;
  assign bus.div_by_zero = r_dbz;
  assign o_state         = r_state;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed vectors plus random operations
// scored against an arithmetic model of add/sub/mul/div and their latencies.
module tb_alu_exec_seq;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_seq_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         dz;
    int           acc;   // cycle counter value during the accept cycle
    int           lat;   // cycles from accept cycle to first out_valid cycle
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   hold_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no progress within bound (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    int unsigned ua, ub;
    ua = a; ub = b;
    e.res = '0; e.hi = '0; e.c = 1'b0; e.dz = 1'b0; e.acc = 0; e.lat = 1;
    case (op)
      2'd0: begin p = ua + ub; e.res = p[W-1:0]; e.c = p[W]; end
      2'd1: begin e.res = a - b; e.c = (a < b); end
      2'd2: begin p = ua * ub; e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = 17; end
      default: begin
        if (b == 0) begin
          e.res = '1; e.hi = a; e.dz = 1'b1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = 17;
        end
      end
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int  k = 0;
    int  waited = 0;
    bit  rdy;
    bit  ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    while (waited < 100) begin
      k   = cyc;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (ok) begin
      e.acc = k;
      exp_q.push_back(e);
    end else begin
      timeout_fail("issue_accept");
    end
    #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 2'($urandom);
    bus.rs1_val  = W'($urandom);
    bus.rs2_val  = W'($urandom);
    @(negedge clk);
  endtask

  task automatic run_rand(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, model(op, a, b));
  endtask

  // Directed vector: the hand-computed literal is what the DUT is held to,
  // and the model is cross-checked against the same literal.
  task automatic run_lit(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [W-1:0] hi,
                         input logic c, input logic dz, input int lat);
    exp_t m;
    exp_t e;
    m = model(op, a, b);
    check("model_pin", {m.res, m.hi}, {res, hi});
    check("model_pin_flags", {m.c, m.dz, 8'(m.lat)}, {c, dz, 8'(lat)});
    e.res = res; e.hi = hi; e.c = c; e.dz = dz; e.acc = 0; e.lat = lat;
    issue(op, a, b, e);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- compare process ----------------
  logic cmp_ev;
  logic cmp_rdy;

  always @(negedge clk) begin
    if (rst_n) begin
      cmp_ev = (exp_q.size() != 0) && ((cyc - exp_q[0].acc) >= exp_q[0].lat);
      check("in_ready", bus.in_ready, exp_q.size() == 0);
      check("out_valid", bus.out_valid, cmp_ev);
      if (cmp_ev) begin
        check("result",      bus.result,      exp_q[0].res);
        check("result_hi",   bus.result_hi,   exp_q[0].hi);
        check("carry",       bus.carry,       exp_q[0].c);
        check("div_by_zero", bus.div_by_zero, exp_q[0].dz);
        cmp_rdy = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus.out_ready = cmp_rdy;
        if (cmp_rdy) void'(exp_q.pop_front());
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_result",    bus.result,      '0);
    check("rst_result_hi", bus.result_hi,   '0);
    check("rst_flags",     {bus.carry, bus.div_by_zero, bus.out_valid}, 3'b000);
    check("rst_in_ready",  bus.in_ready,    1'b1);
    check("rst_state",     dbg_state,       2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_lit(2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
    run_lit(2'd0, 16'h1234, 16'h0001, 16'h1235, 16'h0000, 1'b0, 1'b0, 1);
    run_lit(2'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1);
    run_lit(2'd1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
    run_lit(2'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17);
    run_lit(2'd3, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 1'b0, 17);
    run_lit(2'd3, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b0, 1'b1, 1);
    run_lit(2'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
    drain();

    // Result held in DONE with out_ready low; every cycle is re-checked.
    hold_low = 1'b1;
    run_lit(2'd2, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 1'b0, 17);
    repeat (17 + 5) @(negedge clk);
    hold_low = 1'b0;
    drain();

    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = '1;
        default: b = W'($urandom);
      endcase
      run_rand(op, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of a multiply discards the result.
    run_rand(2'd2, 16'hBEEF, 16'h1357);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result",    bus.result,    '0);
    check("arst_result_hi", bus.result_hi, '0);
    check("arst_flags",     {bus.carry, bus.div_by_zero, bus.out_valid}, 3'b000);
    check("arst_in_ready",  bus.in_ready,  1'b1);
    check("arst_state",     dbg_state,     2'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    run_lit(2'd0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
    run_rand(2'd3, 16'hBEEF, 16'h0013);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    timeout_fail("global_watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
